// File: rtl/cache_wb_pkg.sv
// rtl/cache_wb_pkg.sv - shared FSM state encoding and geometry helper for the write-back cache
package cache_wb_pkg;

    // The numeric values are visible on current_state and must not move.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COMPARE   = 3'd1;
    localparam logic [2:0] ST_WRITEBACK = 3'd2;
    localparam logic [2:0] ST_FILL      = 3'd3;
    localparam logic [2:0] ST_RESPOND   = 3'd4;

    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

endpackage

// File: rtl/cache_data_ram.sv
// rtl/cache_data_ram.sv - single-port synchronous data RAM with registered read
module cache_data_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read returns the old contents on a write cycle; callers never rely on write-through.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_wb_ctrl.sv
// rtl/cache_wb_ctrl.sv - direct-mapped write-back cache between CPU and handshaked SDRAM
module cache_wb_ctrl
    import cache_wb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int INDEX_WIDTH  = 3,
    parameter int OFFSET_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address_cpu,
    input  logic                  wr_rd_cpu,
    input  logic                  cs_cpu,
    input  logic [DATA_WIDTH-1:0] DOut_cpu,
    output logic [DATA_WIDTH-1:0] din_cpu,
    output logic                  rdy_cpu,
    output logic [ADDR_WIDTH-1:0] Address_sdram,
    output logic                  wr_rd_sdram,
    output logic                  mstrb_sdram,
    input  logic                  rdy_sdram,
    input  logic [DATA_WIDTH-1:0] DOut_sdram,
    output logic [DATA_WIDTH-1:0] din_sdram,
    output logic [2:0]            current_state,
    output logic                  hit_o
);

    localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
    localparam int LINES     = 2**INDEX_WIDTH;
    localparam int RAM_AW    = INDEX_WIDTH + OFFSET_WIDTH;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_data_q;
    logic                    req_wr_q;
    logic [OFFSET_WIDTH:0]   cnt_q;
    logic                    rd_pend_q;
    logic [TAG_WIDTH-1:0]    tag_q [LINES];
    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        dirty_q;
    logic                    rdy_q;
    logic                    mstrb_q;
    logic                    wr_rd_sdram_q;
    logic [ADDR_WIDTH-1:0]   addr_sdram_q;
    logic [DATA_WIDTH-1:0]   din_sdram_q;
    logic [DATA_WIDTH-1:0]   din_cpu_q;
    logic                    hit_q;

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [OFFSET_WIDTH-1:0] req_off;
    logic                    hit;
    logic                    line_dirty;
    logic [OFFSET_WIDTH:0]   cnt_d;
    logic                    ram_we;
    logic [RAM_AW-1:0]       ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign req_tag    = req_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_idx    = req_addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off    = req_addr_q[OFFSET_WIDTH-1:0];
    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign line_dirty = valid_q[req_idx] && dirty_q[req_idx];
    // The extra MSB marks "all words moved" so the last word never aliases word 0.
    assign cnt_d      = cnt_q + 1'b1;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = {req_idx, cnt_q[OFFSET_WIDTH-1:0]};
        ram_wdata = DOut_sdram;
        unique case (state_q)
            COMPARE: begin
                ram_addr  = {req_idx, req_off};
                ram_we    = hit && req_wr_q;
                ram_wdata = req_data_q;
            end
            FILL: begin
                ram_we = mstrb_q && rdy_sdram;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    cache_data_ram #(
        .ADDR_WIDTH (RAM_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            req_wr_q      <= 1'b0;
            cnt_q         <= '0;
            rd_pend_q     <= 1'b0;
            valid_q       <= '0;
            dirty_q       <= '0;
            rdy_q         <= 1'b1;
            mstrb_q       <= 1'b0;
            wr_rd_sdram_q <= 1'b0;
            addr_sdram_q  <= '0;
            din_sdram_q   <= '0;
            din_cpu_q     <= '0;
            hit_q         <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            hit_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cs_cpu) begin
                        req_addr_q <= Address_cpu;
                        req_data_q <= DOut_cpu;
                        req_wr_q   <= wr_rd_cpu;
                        rdy_q      <= 1'b0;
                        state_q    <= COMPARE;
                    end
                end
                COMPARE: begin
                    cnt_q     <= '0;
                    rd_pend_q <= 1'b0;
                    if (hit) begin
                        hit_q <= 1'b1;
                        if (req_wr_q) begin
                            dirty_q[req_idx] <= 1'b1;
                        end
                        state_q <= RESPOND;
                    end else if (line_dirty) begin
                        state_q <= WRITEBACK;
                    end else begin
                        valid_q[req_idx] <= 1'b0;
                        dirty_q[req_idx] <= 1'b0;
                        state_q          <= FILL;
                    end
                end
                WRITEBACK: begin
                    // Per word: issue RAM read, then present it to SDRAM, then wait for rdy.
                    if (mstrb_q) begin
                        if (rdy_sdram) begin
                            mstrb_q <= 1'b0;
                            cnt_q   <= cnt_d;
                            if (cnt_d[OFFSET_WIDTH]) begin
                                cnt_q            <= '0;
                                dirty_q[req_idx] <= 1'b0;
                                valid_q[req_idx] <= 1'b0;
                                state_q          <= FILL;
                            end
                        end
                    end else if (rd_pend_q) begin
                        rd_pend_q     <= 1'b0;
                        mstrb_q       <= 1'b1;
                        wr_rd_sdram_q <= 1'b1;
                        addr_sdram_q  <= {tag_q[req_idx], req_idx, cnt_q[OFFSET_WIDTH-1:0]};
                        din_sdram_q   <= ram_rdata;
                    end else begin
                        rd_pend_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (!mstrb_q) begin
                        mstrb_q       <= 1'b1;
                        wr_rd_sdram_q <= 1'b0;
                        addr_sdram_q  <= {req_tag, req_idx, cnt_q[OFFSET_WIDTH-1:0]};
                    end else if (rdy_sdram) begin
                        mstrb_q <= 1'b0;
                        cnt_q   <= cnt_d;
                        if (cnt_d[OFFSET_WIDTH]) begin
                            cnt_q            <= '0;
                            tag_q[req_idx]   <= req_tag;
                            valid_q[req_idx] <= 1'b1;
                            dirty_q[req_idx] <= 1'b0;
                            state_q          <= COMPARE;
                        end
                    end
                end
                RESPOND: begin
                    rdy_q <= 1'b1;
                    if (!req_wr_q) begin
                        din_cpu_q <= ram_rdata;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign din_cpu       = din_cpu_q;
    assign rdy_cpu       = rdy_q;
    assign Address_sdram = addr_sdram_q;
    assign wr_rd_sdram   = wr_rd_sdram_q;
    assign mstrb_sdram   = mstrb_q;
    assign din_sdram     = din_sdram_q;
    assign current_state = state_q;
    assign hit_o         = hit_q;

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// tb/tb_cache_wb_ctrl.sv - self-checking bench for cache_wb_ctrl with SDRAM responder and memory model
module tb_cache_wb_ctrl;

    localparam int WPL = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Address_cpu;
    logic        wr_rd_cpu;
    logic        cs_cpu;
    logic [7:0]  DOut_cpu;
    logic [7:0]  din_cpu;
    logic        rdy_cpu;
    logic [15:0] Address_sdram;
    logic        wr_rd_sdram;
    logic        mstrb_sdram;
    logic        rdy_sdram;
    logic [7:0]  DOut_sdram;
    logic [7:0]  din_sdram;
    logic [2:0]  current_state;
    logic        hit_o;

    always #5 clk = ~clk;

    cache_wb_ctrl #(
        .ADDR_WIDTH   (16),
        .DATA_WIDTH   (8),
        .INDEX_WIDTH  (3),
        .OFFSET_WIDTH (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Address_cpu   (Address_cpu),
        .wr_rd_cpu     (wr_rd_cpu),
        .cs_cpu        (cs_cpu),
        .DOut_cpu      (DOut_cpu),
        .din_cpu       (din_cpu),
        .rdy_cpu       (rdy_cpu),
        .Address_sdram (Address_sdram),
        .wr_rd_sdram   (wr_rd_sdram),
        .mstrb_sdram   (mstrb_sdram),
        .rdy_sdram     (rdy_sdram),
        .DOut_sdram    (DOut_sdram),
        .din_sdram     (din_sdram),
        .current_state (current_state),
        .hit_o         (hit_o)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
    } xfer_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  golden    [65536];
    logic [7:0]  sdram_mem [65536];
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [7:0]  m_tag   [8];
    xfer_t       obs_q [$];
    xfer_t       exp_q [$];
    int          hit_cnt    = 0;
    int          stall_word = -1;
    int          stall_len  = 0;
    int          rsp_cnt    = 0;
    bit          prev_mstrb = 0;
    bit          prev_done  = 0;
    logic [24:0] prev_bus   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SDRAM responder: completes each word two cycles after mstrb, optionally stretched.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            rdy_sdram  = 1'b0;
            DOut_sdram = 8'h00;
            rsp_cnt    = 0;
            prev_mstrb = 0;
            prev_done  = 0;
        end else begin
            if (hit_o === 1'b1) hit_cnt++;
            if (prev_done) begin
                chk("mstrb_gap", {31'b0, mstrb_sdram}, 32'd0);
            end else if (prev_mstrb && mstrb_sdram) begin
                chk("stall_stable", {7'b0, Address_sdram, wr_rd_sdram, din_sdram}, {7'b0, prev_bus});
            end
            prev_mstrb = mstrb_sdram;
            prev_bus   = {Address_sdram, wr_rd_sdram, din_sdram};
            prev_done  = 0;
            if (mstrb_sdram) begin
                rsp_cnt++;
                if (rsp_cnt >= 2 + ((obs_q.size() == stall_word) ? stall_len : 0)) begin
                    rdy_sdram = 1'b1;
                    rsp_cnt   = 0;
                    prev_done = 1;
                    obs_q.push_back({Address_sdram, wr_rd_sdram});
                    if (wr_rd_sdram) begin
                        chk("wb_data", {24'b0, din_sdram}, {24'b0, golden[Address_sdram]});
                        sdram_mem[Address_sdram] = din_sdram;
                        DOut_sdram = 8'($urandom);
                    end else begin
                        DOut_sdram = sdram_mem[Address_sdram];
                    end
                end else begin
                    rdy_sdram  = 1'b0;
                    DOut_sdram = 8'($urandom);
                end
            end else begin
                // Spurious rdy while no request is outstanding must be ignored.
                rdy_sdram  = ($urandom_range(0, 3) == 0);
                DOut_sdram = 8'($urandom);
                rsp_cnt    = 0;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                for (int w = 0; w < WPL; w++) begin
                    golden[{m_tag[i], 3'(i), 5'(w)}] = sdram_mem[{m_tag[i], 3'(i), 5'(w)}];
                end
            end
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = 8'h00;
        end
    endtask

    task automatic do_req(input logic [15:0] a, input logic wr, input logic [7:0] d,
                          input bit poke, output int lat);
        logic [2:0] idx;
        logic [7:0] tg;
        logic [7:0] exp_rd;
        bit         hit;
        bit         ok;
        idx = a[7:5];
        tg  = a[15:8];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_q.delete();
        obs_q.delete();
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int w = 0; w < WPL; w++) exp_q.push_back({m_tag[idx], idx, 5'(w), 1'b1});
            end
            for (int w = 0; w < WPL; w++) exp_q.push_back({tg, idx, 5'(w), 1'b0});
        end
        hit_cnt = 0;
        @(negedge clk);
        Address_cpu = a;
        wr_rd_cpu   = wr;
        DOut_cpu    = d;
        cs_cpu      = 1'b1;
        @(negedge clk);
        cs_cpu      = 1'b0;
        Address_cpu = 16'($urandom);
        DOut_cpu    = 8'($urandom);
        wr_rd_cpu   = 1'($urandom);
        lat = 1;
        while (rdy_cpu !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (poke) begin
                cs_cpu      = (lat < 12);
                Address_cpu = 16'hBEEF;
                wr_rd_cpu   = 1'b1;
            end
        end
        cs_cpu = 1'b0;
        chk("req_done_in_budget", {31'b0, lat < 2000}, 32'd1);
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
        if (!hit) m_dirty[idx] = 0;
        exp_rd = golden[a];
        if (wr) begin
            golden[a]    = d;
            m_dirty[idx] = 1;
        end
        ok = (obs_q.size() == exp_q.size());
        for (int i = 0; i < exp_q.size() && ok; i++) begin
            if (obs_q[i] !== exp_q[i]) ok = 0;
        end
        chk("xfer_count", obs_q.size(), exp_q.size());
        chk("xfer_seq", {31'b0, ok}, 32'd1);
        chk("hit_pulses", hit_cnt, 32'd1);
        if (!wr) chk("rd_data", {24'b0, din_cpu}, {24'b0, exp_rd});
        if (hit) chk("hit_latency", lat, 32'd3);
        chk("state_idle", {29'b0, current_state}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n;
        logic [7:0]  tags [4];
        logic [15:0] ra;

        for (int i = 0; i < 65536; i++) begin
            golden[i]    = i[7:0] ^ i[15:8];
            sdram_mem[i] = i[7:0] ^ i[15:8];
        end
        model_reset();
        rst         = 1'b0;
        cs_cpu      = 1'b0;
        wr_rd_cpu   = 1'b0;
        Address_cpu = 16'h0000;
        DOut_cpu    = 8'h00;
        rdy_sdram   = 1'b0;
        DOut_sdram  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rdy_cpu", {31'b0, rdy_cpu}, 32'd1);
        chk("rst_mstrb", {31'b0, mstrb_sdram}, 32'd0);
        chk("rst_wr_rd", {31'b0, wr_rd_sdram}, 32'd0);
        chk("rst_addr_sdram", {16'b0, Address_sdram}, 32'd0);
        chk("rst_din_sdram", {24'b0, din_sdram}, 32'd0);
        chk("rst_din_cpu", {24'b0, din_cpu}, 32'd0);
        chk("rst_hit", {31'b0, hit_o}, 32'd0);
        chk("rst_state", {29'b0, current_state}, 32'd0);
        rst = 1'b1;

        // Cold read miss: whole line filled from SDRAM.
        do_req(16'h1234, 1'b0, 8'h00, 1'b0, lat);
        chk("t1_din", {24'b0, din_cpu}, 32'h26);
        chk("t1_first_addr", {15'b0, obs_q[0]}, {15'b0, 16'h1220, 1'b0});
        chk("t1_last_addr", {15'b0, obs_q[31]}, {15'b0, 16'h123F, 1'b0});

        // Write hit then read hit.
        do_req(16'h1234, 1'b1, 8'hA5, 1'b0, lat);
        chk("t2_wr_latency", lat, 32'd3);
        do_req(16'h1234, 1'b0, 8'h00, 1'b0, lat);
        chk("t2_din", {24'b0, din_cpu}, 32'hA5);

        // Conflict miss on a dirty line: writeback then fill.
        do_req(16'h5634, 1'b0, 8'h00, 1'b0, lat);
        chk("t3_din", {24'b0, din_cpu}, 32'h62);
        chk("t3_sdram_1234", {24'b0, sdram_mem[16'h1234]}, 32'hA5);
        chk("t3_first_wb", {15'b0, obs_q[0]}, {15'b0, 16'h1220, 1'b1});
        chk("t3_first_fill", {15'b0, obs_q[32]}, {15'b0, 16'h5620, 1'b0});

        // Long SDRAM stall in the middle of a fill.
        stall_word = 5;
        stall_len  = 10;
        do_req(16'h9A10, 1'b0, 8'h00, 1'b0, lat);
        stall_word = -1;
        stall_len  = 0;
        chk("t4_din", {24'b0, din_cpu}, 32'h8A);
        chk("t4_stretched", {31'b0, lat > 32 * 3 + 10}, 32'd1);

        // Reset while word 7 of a fill is outstanding.
        obs_q.delete();
        @(negedge clk);
        Address_cpu = 16'h1234;
        wr_rd_cpu   = 1'b0;
        cs_cpu      = 1'b1;
        @(negedge clk);
        cs_cpu = 1'b0;
        n = 0;
        while (obs_q.size() < 7 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_word7", {31'b0, n < 1000}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t5_pre_addr", {16'b0, Address_sdram}, 32'h1227);
        chk("t5_pre_mstrb", {31'b0, mstrb_sdram}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("t5_rdy_cpu", {31'b0, rdy_cpu}, 32'd1);
        chk("t5_mstrb", {31'b0, mstrb_sdram}, 32'd0);
        chk("t5_wr_rd", {31'b0, wr_rd_sdram}, 32'd0);
        chk("t5_addr_sdram", {16'b0, Address_sdram}, 32'd0);
        chk("t5_din_cpu", {24'b0, din_cpu}, 32'd0);
        chk("t5_state", {29'b0, current_state}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        do_req(16'h1234, 1'b0, 8'h00, 1'b0, lat);
        chk("t5_reread_miss", obs_q.size(), 32'd32);
        chk("t5_reread_din", {24'b0, din_cpu}, 32'hA5);

        // cs_cpu pulsed while a miss is in progress.
        do_req(16'h7E00, 1'b0, 8'h00, 1'b1, lat);
        chk("t6_din", {24'b0, din_cpu}, 32'h7E);

        // Random traffic over a few aliasing tags.
        tags[0] = 8'h12;
        tags[1] = 8'h56;
        tags[2] = 8'h9A;
        tags[3] = 8'h7E;
        for (int k = 0; k < 60; k++) begin
            ra = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 5'($urandom)};
            do_req(ra, 1'($urandom), 8'($urandom), 1'b0, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
